ysyx_24090003_inst_encoder: RTL and testbench
=============================================

// Module: ysyx_24090003_inst_encoder
// PURPOSE
//  Inverse of the immediate-generation path: packs opcode/funct3/registers/32-bit immediate into
//  RV32I I/S/B/U/J instruction words. Also expands the LI pseudo-op into ADDI, or LUI(+ADDI).
//  Used by the boot/self-test instruction stream generator and by the bench to build stimulus.
//  Valid/ready on both sides. One registered output word. Up to 1 word/cycle.
// PARAMETERS
//  none (RV32I fixed: XLEN=32, 5-bit register indices)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   request present
//  in_ready   out  1   request accepted when in_valid&&in_ready at posedge
//  in_op      in   3   001 I, 010 S, 011 B, 100 U, 101 J, 110 LI; 000/111 illegal
//  in_opcode  in   7   inst[6:0]; ignored for LI
//  in_funct3  in   3   inst[14:12]; ignored for U/J/LI
//  in_rd      in   5   destination register
//  in_rs1     in   5   source 1
//  in_rs2     in   5   source 2 (S/B only)
//  in_imm     in   32  immediate, full-width two's complement byte offset/value
//  out_valid  out  1   out_inst valid
//  out_ready  in   1   consumer takes word when out_valid&&out_ready at posedge
//  out_inst   out  32  encoded instruction
//  out_last   out  1   final word of the current request
//  out_err    out  1   immediate range/alignment violation or illegal in_op for this word
// BEHAVIOUR
//  Reset: state IDLE. out_valid=0, out_inst=0, out_last=0, out_err=0. Any pending second LI word is discarded.
//  FSM:
//   IDLE  -> empty; in_ready=1.
//   ONE   -> holds final word; in_ready=out_ready.
//   FIRST -> holds LUI with ADDI pending; in_ready=0.
//  Transitions:
//   Accept in IDLE/ONE -> FIRST if LI needs 2 words, else ONE.
//   ONE & out_ready & !accept -> IDLE.
//   FIRST & out_ready -> load ADDI, ONE.
//   FIRST & !out_ready -> stay.
//  Latency: word visible the cycle after acceptance. Back-to-back in ONE gives 1 word/cycle.
//  While out_valid&&!out_ready, out_inst/out_last/out_err hold stable.
//  Encodings (rd=[11:7], rs1=[19:15], rs2=[24:20], f3=[14:12], op=[6:0]):
//   I {imm[11:0],rs1,f3,rd,op}; err unless imm is sign-extension of imm[11:0]
//   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; err as I
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; err if imm[0]!=0 or imm outside 13-bit signed
//   U {imm[31:12],rd,op}; err if imm[11:0]!=0
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; err if imm[0]!=0 or imm outside 21-bit signed
//   illegal in_op -> out_inst=0, err=1, last=1
//  Errored words are still emitted with truncated fields.
//  LI (never errors):
//   imm in [-2048,2047] -> ADDI rd,x0,imm (op 0010011, f3 000), single word.
//   Otherwise: hi=(imm+32'h800)[31:12] (mod 2^32), lo=imm[11:0].
//     Emit LUI rd,hi (op 0110111), last=0.
//     Then ADDI rd,rd,lo, last=1.
//     If lo==0, emit LUI only, with last=1.
//   rd=0 is not special-cased.
//  out_last=1 on every single-word request.
// TESTING
//  1 I: op=0x13,f3=0,rd=1,rs1=0,imm=0xFFFFFFFF -> 0xFFF00093 next cycle, last=1,err=0
//  2 LI rd=5,imm=0x12345678 -> 0x123452B7(last=0) then 0x67828293(last=1); in_ready=0 in between
//  3 LI rd=1,imm=0x00001800 -> 0x000020B7 then 0x80008093; LI imm=0x00005000 -> 0x000050B7 only, last=1
//  4 B op=0x63,rs1=1,rs2=2,imm=-4 -> 0xFE208EE3; imm=-3 -> err=1. J op=0x6F,rd=1,imm=8 -> 0x008000EF
//  5 out_ready=0 for 3 cycles in FIRST -> word stable, in_ready=0; then 4 back-to-back I requests
//    with out_ready=1 -> 4 words in 4 consecutive cycles
//  6 rst=1 while in FIRST -> next cycle out_valid=0, in_ready=1; pending ADDI never appears

Source files
------------

// File: rtl/ysyx_24090003_inst_encoder.sv
// ysyx_24090003_inst_encoder
// Packs opcode/funct3/register indices/32-bit immediate into RV32I I/S/B/U/J
// instruction words, and expands the LI pseudo-op into ADDI or LUI(+ADDI).
// One registered output word with valid/ready handshakes on both sides.
module ysyx_24090003_inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        FIRST = 2'd2
    } state_t;

    // Result of encoding one request: first word, optional second (ADDI) word.
    typedef struct packed {
        logic [31:0] first;
        logic [31:0] second;
        logic        two;
        logic        last;
        logic        err;
    } enc_t;

    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    // Encode a full request; errored words still carry the truncated fields.
    function automatic enc_t encode_req(
        input logic [2:0]  op,
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        enc_t        e;
        logic [31:0] hi_sum;
        e.first  = 32'd0;
        e.second = 32'd0;
        e.two    = 1'b0;
        e.last   = 1'b1;
        e.err    = 1'b0;
        hi_sum   = imm + 32'h0000_0800;
        case (op)
            3'b001: begin
                e.first = {imm[11:0], rs1, f3, rd, opc};
                e.err   = (imm[31:11] != {21{imm[11]}});
            end
            3'b010: begin
                e.first = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                e.err   = (imm[31:11] != {21{imm[11]}});
            end
            3'b011: begin
                e.first = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                e.err   = imm[0] | (imm[31:12] != {20{imm[12]}});
            end
            3'b100: begin
                e.first = {imm[31:12], rd, opc};
                e.err   = (imm[11:0] != 12'd0);
            end
            3'b101: begin
                e.first = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                e.err   = imm[0] | (imm[31:20] != {12{imm[20]}});
            end
            3'b110: begin
                if (imm[31:11] == {21{imm[11]}}) begin
                    // Fits the 12-bit ADDI immediate: single word from x0.
                    e.first = {imm[11:0], 5'd0, 3'b000, rd, OPC_ADDI};
                end else begin
                    // The +0x800 rounding compensates for ADDI sign-extending lo.
                    e.first = {hi_sum[31:12], rd, OPC_LUI};
                    if (imm[11:0] != 12'd0) begin
                        e.second = {imm[11:0], rd, 3'b000, rd, OPC_ADDI};
                        e.two    = 1'b1;
                        e.last   = 1'b0;
                    end else begin
                        e.two    = 1'b0;
                        e.last   = 1'b1;
                    end
                end
            end
            default: begin
                e.first = 32'd0;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    state_t      state_r;
    state_t      state_n_s;
    logic [31:0] inst_r;
    logic [31:0] inst_n_s;
    logic        last_r;
    logic        last_n_s;
    logic        err_r;
    logic        err_n_s;
    logic [31:0] pend_r;
    logic [31:0] pend_n_s;
    enc_t        enc_s;
    logic        accept_s;

    // Encode the incoming request combinationally.
    always_comb begin
        enc_s = encode_req(in_op, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm);
    end

    // Input-side ready: free when empty, or when the held final word leaves this cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            IDLE:    in_ready = 1'b1;
            ONE:     in_ready = out_ready;
            FIRST:   in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_r != IDLE);
    assign out_inst  = inst_r;
    assign out_last  = last_r;
    assign out_err   = err_r;

    // Next-state and next output word selection.
    always_comb begin
        state_n_s = state_r;
        inst_n_s  = inst_r;
        last_n_s  = last_r;
        err_n_s   = err_r;
        pend_n_s  = pend_r;
        case (state_r)
            IDLE, ONE: begin
                if (accept_s) begin
                    inst_n_s  = enc_s.first;
                    last_n_s  = enc_s.last;
                    err_n_s   = enc_s.err;
                    pend_n_s  = enc_s.second;
                    state_n_s = enc_s.two ? FIRST : ONE;
                end else if ((state_r == ONE) && out_ready) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = state_r;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    inst_n_s  = pend_r;
                    last_n_s  = 1'b1;
                    err_n_s   = 1'b0;
                    state_n_s = ONE;
                end else begin
                    state_n_s = FIRST;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending second LI word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            inst_r  <= 32'd0;
            last_r  <= 1'b0;
            err_r   <= 1'b0;
            pend_r  <= 32'd0;
        end else begin
            state_r <= state_n_s;
            inst_r  <= inst_n_s;
            last_r  <= last_n_s;
            err_r   <= err_n_s;
            pend_r  <= pend_n_s;
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_inst_encoder.sv
// Testbench for ysyx_24090003_inst_encoder: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_ysyx_24090003_inst_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected words still to appear: {err, last, inst}, head is on the output now.
    logic [33:0] q[$];
    bit          chk_en = 1'b0;

    ysyx_24090003_inst_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_last(out_last), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder written from the instruction-format rules with plain arithmetic.
    task automatic model_expand(input logic [2:0] op, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm,
                                output int n, output logic [33:0] w0, output logic [33:0] w1);
        logic [31:0] o, f, d, a, b, inst, hi, lo;
        logic        err;
        int          s;
        o = {25'd0, opc}; f = {29'd0, f3}; d = {27'd0, rd}; a = {27'd0, rs1}; b = {27'd0, rs2};
        s = $signed(imm);
        n = 1; w1 = 34'd0; err = 1'b0; inst = 32'd0;
        case (op)
            3'd1: begin
                inst = ((imm & 32'hFFF) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
                err  = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                inst = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
                     | ((imm & 32'h1F) << 7) | o;
                err  = !(s >= -2048 && s <= 2047);
            end
            3'd3: begin
                inst = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20)
                     | (a << 15) | (f << 12) | (((imm >> 1) & 32'hF) << 8)
                     | (((imm >> 11) & 32'h1) << 7) | o;
                err  = ((imm % 32'd2) != 32'd0) || s < -4096 || s > 4095;
            end
            3'd4: begin
                inst = (imm & 32'hFFFFF000) | (d << 7) | o;
                err  = (imm & 32'hFFF) != 32'd0;
            end
            3'd5: begin
                inst = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000FF000) | (d << 7) | o;
                err  = ((imm % 32'd2) != 32'd0) || s < -1048576 || s > 1048575;
            end
            3'd6: begin
                if (s >= -2048 && s <= 2047) begin
                    inst = ((imm & 32'hFFF) << 20) | (d << 7) | 32'h13;
                end else begin
                    hi   = (imm + 32'h800) & 32'hFFFFF000;
                    lo   = imm & 32'hFFF;
                    inst = hi | (d << 7) | 32'h37;
                    if (lo != 32'd0) begin
                        n  = 2;
                        w1 = {1'b0, 1'b1, (lo << 20) | (d << 15) | (d << 7) | 32'h13};
                    end
                end
            end
            default: begin
                inst = 32'd0;
                err  = 1'b1;
            end
        endcase
        w0 = {err, (n == 1), inst};
    endtask

    // Per-cycle compare of the DUT against the model, then advance the model across the edge.
    task automatic step();
        bit          exp_valid, exp_ready;
        int          n;
        logic [33:0] w0, w1;
        #1;
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            if (exp_valid) begin
                chk("out_inst", out_inst, q[0][31:0]);
                chk("out_last", {31'd0, out_last}, {31'd0, q[0][32]});
                chk("out_err", {31'd0, out_err}, {31'd0, q[0][33]});
            end
        end
        if (rst) begin
            q.delete();
        end else begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                model_expand(in_op, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, n, w0, w1);
                q.push_back(w0);
                if (n == 2) q.push_back(w1);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [2:0] op, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
        in_valid = 1'b1; in_op = op; in_opcode = opc; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // Literal expectations that pin the reference model itself.
    task automatic pin(input string name, input logic [2:0] op, input logic [6:0] opc,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input int exp_n,
                       input logic [33:0] exp_w0, input logic [31:0] exp_w1);
        int          n;
        logic [33:0] w0, w1;
        model_expand(op, opc, 3'd0, rd, rs1, rs2, imm, n, w0, w1);
        chk({name, "_n"}, n, exp_n);
        chk({name, "_w0"}, w0[31:0], exp_w0[31:0]);
        chk({name, "_w0flags"}, {30'd0, w0[33:32]}, {30'd0, exp_w0[33:32]});
        if (exp_n == 2) chk({name, "_w1"}, w1[31:0], exp_w1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        req(3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b0;

        pin("pinI",   3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1, {2'b01, 32'hFFF00093}, 32'd0);
        pin("pinLI2", 3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345678, 2, {2'b00, 32'h123452B7}, 32'h67828293);
        pin("pinLI3", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00001800, 2, {2'b00, 32'h000020B7}, 32'h80008093);
        pin("pinLI1", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00005000, 1, {2'b01, 32'h000050B7}, 32'd0);
        pin("pinB",   3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1, {2'b01, 32'hFE208EE3}, 32'd0);
        pin("pinBerr",3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFD, 1, {2'b11, 32'hFE208EE3}, 32'd0);
        pin("pinJ",   3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 32'h00000008, 1, {2'b01, 32'h008000EF}, 32'd0);
        pin("pinIll", 3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 32'h00000000, 1, {2'b11, 32'h00000000}, 32'd0);

        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        step();

        // Directed scenarios from the datasheet examples.
        out_ready = 1'b1;
        req(3'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF); step();
        req(3'd6, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678); step();
        in_valid = 1'b0; step();
        req(3'd6, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00001800); step();
        in_valid = 1'b0; step();
        req(3'd6, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00005000); step();
        req(3'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC); step();
        req(3'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFD); step();
        req(3'd5, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000008); step();
        req(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000000); step();
        in_valid = 1'b0; step();

        // Stall in FIRST for three cycles, then four back-to-back I requests.
        out_ready = 1'b0;
        req(3'd6, 7'h00, 3'd0, 5'd7, 5'd0, 5'd0, 32'hCAFEB123); step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            req(3'd1, 7'h13, 3'd0, 5'(i + 2), 5'(i), 5'd0, 32'(i * 100));
            step();
            chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0; step(); step();

        // Reset while the ADDI half of LI is pending.
        out_ready = 1'b0;
        req(3'd6, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678); step();
        in_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_first_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_first_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic with random backpressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] imm;
            case ($urandom % 4)
                0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1:       imm = $urandom;
                2:       imm = (32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000) & 32'hFFFFFFFE;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            req(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), imm);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 250) == 0;
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
